// File: rtl/conv_pkg.sv
// Shared types and helpers for the 1-D streaming convolver: FSM states,
// address-width helper and the output saturation function.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } conv_state_t;

    // Address width for a memory of the given depth; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Clamp a signed value into the signed range of an out_w-bit word.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] i_val,
                                                     input int                 out_w);
        logic signed [63:0] w_max;
        logic signed [63:0] w_min;
        w_max = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        w_min = -(64'sd1 <<< (out_w - 1));
        if (i_val > w_max) return w_max;
        if (i_val < w_min) return w_min;
        return i_val;
    endfunction

endpackage

// File: rtl/conv_mem_loader.sv
// Operand memory with a valid/ready write port that fills once, then holds until cleared.
// Read data is registered: one cycle from address to o_rd_data. Ready drops the cycle after the last word.
module conv_mem_loader
    import conv_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    input  logic          i_clr,
    output logic          o_full,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic          r_full;
    logic [DW-1:0] r_rd_data;
    logic          w_wr;

    assign w_wr      = i_valid && !r_full;
    assign o_ready   = !r_full;
    assign o_full    = r_full;
    assign o_rd_data = r_rd_data;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_wr_ptr <= '0;
            r_full   <= 1'b0;
        end else if (w_wr) begin
            if (r_wr_ptr == AW'(DEPTH - 1)) begin
                r_wr_ptr <= '0;
                r_full   <= 1'b1;
            end else begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
        end
    end

    // Contents are left as-is on clear; the pointer and full flag define emptiness.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
        r_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/conv_1d_stream.sv
// Valid-mode 1-D convolver: y[n] = sum_k x[n+k]*f[k], one pipelined MAC, valid/ready in and out.
// First y is F_SIZE+3 cycles after CALC entry (F_SIZE+4 with CONV_SAT_EN); output held until taken.
module conv_1d_stream
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH_X = 8,
    parameter int DATA_WIDTH_F = 8,
    parameter int X_SIZE       = 8,
    parameter int F_SIZE       = 4,
    parameter int ACC_WIDTH    = DATA_WIDTH_X + DATA_WIDTH_F + $clog2(F_SIZE),
    parameter int OUT_WIDTH    = ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid_x,
    output logic                        s_ready_x,
    input  logic [DATA_WIDTH_X-1:0]     s_data_in_x,
    input  logic                        s_valid_f,
    output logic                        s_ready_f,
    input  logic [DATA_WIDTH_F-1:0]     s_data_in_f,
    input  logic                        keep_f,
    output logic                        m_valid_y,
    input  logic                        m_ready_y,
    output logic signed [OUT_WIDTH-1:0] m_data_out_y
);

    localparam int XAW    = addr_w(X_SIZE);
    localparam int FAW    = addr_w(F_SIZE);
    localparam int PW     = DATA_WIDTH_X + DATA_WIDTH_F;
    localparam int N_LAST = X_SIZE - F_SIZE;

    conv_state_t r_state, w_state_nxt;

    logic [XAW-1:0] r_n;
    logic [FAW-1:0] r_tap;
    logic           r_issued;
    logic           w_issue;
    logic           w_hs;
    logic           w_last_n;
    logic           w_x_full, w_f_full;
    logic           w_x_clr, w_f_clr;
    logic [XAW-1:0] w_addr_x;
    logic [DATA_WIDTH_X-1:0] w_x_rd;
    logic [DATA_WIDTH_F-1:0] w_f_rd;

    logic                        r_s1_vld, r_s1_first, r_s1_last;
    logic                        r_s2_vld, r_s2_first, r_s2_last;
    logic signed [PW-1:0]        r_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_acc_vld;
    logic                        w_out_load;
    logic signed [OUT_WIDTH-1:0] w_out_dat;
    logic                        r_valid_y;
    logic signed [OUT_WIDTH-1:0] r_data_y;

    assign w_hs      = r_valid_y && m_ready_y;
    assign w_last_n  = (r_n == XAW'(N_LAST));
    assign w_issue   = (r_state == CALC) && !r_issued;
    assign w_addr_x  = r_n + XAW'(r_tap);
    assign m_valid_y    = r_valid_y;
    assign m_data_out_y = r_data_y;

    conv_mem_loader #(.DW(DATA_WIDTH_X), .DEPTH(X_SIZE)) u_x_mem (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (s_valid_x),
        .o_ready   (s_ready_x),
        .i_data    (s_data_in_x),
        .i_clr     (w_x_clr),
        .o_full    (w_x_full),
        .i_rd_addr (w_addr_x),
        .o_rd_data (w_x_rd)
    );

    conv_mem_loader #(.DW(DATA_WIDTH_F), .DEPTH(F_SIZE)) u_f_mem (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (s_valid_f),
        .o_ready   (s_ready_f),
        .i_data    (s_data_in_f),
        .i_clr     (w_f_clr),
        .o_full    (w_f_full),
        .i_rd_addr (r_tap),
        .o_rd_data (w_f_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= LOAD;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_clr     = 1'b0;
        w_f_clr     = 1'b0;
        case (r_state)
            LOAD: if (w_x_full && w_f_full) w_state_nxt = CALC;
            CALC: if (r_s2_vld && r_s2_last) w_state_nxt = HOLD;
            HOLD: if (w_hs) begin
                if (w_last_n) begin
                    w_state_nxt = LOAD;
                    w_x_clr     = 1'b1;
                    w_f_clr     = !keep_f;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    // Tap counter runs once per CALC visit; output index advances on each handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_n      <= '0;
            r_tap    <= '0;
            r_issued <= 1'b0;
        end else begin
            if (r_state != CALC) begin
                r_tap    <= '0;
                r_issued <= 1'b0;
            end else if (w_issue) begin
                if (r_tap == FAW'(F_SIZE - 1)) begin
                    r_tap    <= '0;
                    r_issued <= 1'b1;
                end else begin
                    r_tap <= r_tap + FAW'(1);
                end
            end
            if (r_state == HOLD && w_hs)
                r_n <= w_last_n ? '0 : r_n + XAW'(1);
        end
    end

    assign w_prod_ext = ACC_WIDTH'(r_prod);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_prod     <= '0;
            r_acc      <= '0;
            r_acc_vld  <= 1'b0;
        end else begin
            r_s1_vld   <= w_issue;
            r_s1_first <= w_issue && (r_tap == '0);
            r_s1_last  <= w_issue && (r_tap == FAW'(F_SIZE - 1));
            r_s2_vld   <= r_s1_vld;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_prod     <= $signed(w_x_rd) * $signed(w_f_rd);
            if (r_s2_vld)
                r_acc <= r_s2_first ? w_prod_ext : r_acc + w_prod_ext;
            r_acc_vld  <= r_s2_vld && r_s2_last;
        end
    end

`ifdef CONV_SAT_EN
    logic                        r_sat_vld;
    logic signed [OUT_WIDTH-1:0] r_sat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sat_vld <= 1'b0;
            r_sat     <= '0;
        end else begin
            r_sat_vld <= r_acc_vld;
            r_sat     <= OUT_WIDTH'(sat_trunc(64'(r_acc), OUT_WIDTH));
        end
    end

    assign w_out_load = r_sat_vld;
    assign w_out_dat  = r_sat;
`else
    assign w_out_load = r_acc_vld;
    assign w_out_dat  = r_acc[OUT_WIDTH-1:0];
`endif

    // Next result only arrives after the handshake, so a load never collides with a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_y <= 1'b0;
            r_data_y  <= '0;
        end else if (w_out_load) begin
            r_valid_y <= 1'b1;
            r_data_y  <= w_out_dat;
        end else if (m_ready_y) begin
            r_valid_y <= 1'b0;
        end
    end

endmodule
